// File: rtl/swan_pkg.sv
// SWAN serial core shared definitions.
// Holds the controller state encoding, the default round-constant increment,
// the parameter legality check and the forward/inverse key-register steps.
// The key-step functions work on maximum-width vectors (256-bit key,
// 128-bit side) and take the real widths as arguments, so every build
// shares one implementation.
package swan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRECOMP,
        ST_RUN,
        ST_DONE
    } swan_state_t;

    localparam logic [31:0] SWAN_DELTA = 32'h9e3779b9;
    localparam int KMAX = 256;
    localparam int SMAX = 128;

    function automatic bit legal_sizes(input int block_size, input int key_size,
                                       input int rounds, input int pd);
        bit bs_ok;
        bit ks_ok;
        bs_ok = (block_size == 64) || (block_size == 128) || (block_size == 256);
        ks_ok = (key_size == 128) || (key_size == 256);
        return bs_ok && ks_ok && (key_size % (block_size / 2) == 0)
               && (rounds >= 1) && (pd > 0) && (pd < key_size);
    endfunction

    // One forward step: rotate right by pd, then add the already-advanced
    // round constant into the least-significant side word.
    function automatic logic [KMAX-1:0] key_fwd(input logic [KMAX-1:0] k,
                                                 input logic [SMAX-1:0] rd_next,
                                                 input int key_size, input int side_size,
                                                 input int pd);
        logic [KMAX-1:0] rot;
        logic [KMAX-1:0] low_mask;
        logic [KMAX-1:0] sum;
        rot = '0;
        for (int i = 0; i < KMAX; i++) begin
            if (i < key_size) rot[i] = k[(i + pd) % key_size];
        end
        low_mask = (KMAX'(1) << side_size) - KMAX'(1);
        sum = (rot & low_mask) + KMAX'(rd_next);
        return (rot & ~low_mask) | (sum & low_mask);
    endfunction

    // Exact inverse of key_fwd: subtract the current constant, rotate left.
    function automatic logic [KMAX-1:0] key_inv(input logic [KMAX-1:0] k,
                                                 input logic [SMAX-1:0] rd_cur,
                                                 input int key_size, input int side_size,
                                                 input int pd);
        logic [KMAX-1:0] low_mask;
        logic [KMAX-1:0] diff;
        logic [KMAX-1:0] tmp;
        logic [KMAX-1:0] rot;
        low_mask = (KMAX'(1) << side_size) - KMAX'(1);
        diff = (k & low_mask) - KMAX'(rd_cur);
        tmp = (k & ~low_mask) | (diff & low_mask);
        rot = '0;
        for (int i = 0; i < KMAX; i++) begin
            if (i < key_size) rot[i] = tmp[(i + key_size - pd) % key_size];
        end
        return rot;
    endfunction

endpackage

// File: rtl/swan_serial_core_round_f.sv
// SWAN round function F: key mixing, bitsliced 4-bit S-box layer,
// per-quarter linear diffusion, then a quarter-word rotation.
// Ports: x (data half), sk (round key), y (F output); all SIDE_SIZE bits.
module swan_round_f #(
    parameter int SIDE_SIZE = 32
) (
    input  logic [SIDE_SIZE-1:0] x,
    input  logic [SIDE_SIZE-1:0] sk,
    output logic [SIDE_SIZE-1:0] y
);
    localparam int Q = SIDE_SIZE / 4;
    localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;

    logic [SIDE_SIZE-1:0] t;
    logic [3:0][Q-1:0]    a;
    logic [3:0][Q-1:0]    b;
    logic [3:0][Q-1:0]    c;
    logic [3:0]           nib;
    logic [3:0]           sv;

    assign t = x ^ sk;

    always_comb begin
        a   = '0;
        b   = '0;
        c   = '0;
        nib = '0;
        sv  = '0;
        for (int j = 0; j < 4; j++) a[j] = t[SIDE_SIZE-1-j*Q -: Q];
        // Column i of the four quarters forms one S-box input, quarter 0 is the MSB.
        for (int i = 0; i < Q; i++) begin
            nib = {a[0][i], a[1][i], a[2][i], a[3][i]};
            sv  = SBOX[{~nib, 2'b11} -: 4];
            b[0][i] = sv[3];
            b[1][i] = sv[2];
            b[2][i] = sv[1];
            b[3][i] = sv[0];
        end
        for (int j = 0; j < 4; j++) begin
            c[j] = b[j] ^ {b[j][Q-2:0], b[j][Q-1]} ^ {b[j][Q-8:0], b[j][Q-1:Q-7]};
        end
    end

    assign y = {c[1], c[2], c[3], {c[0][Q-4:0], c[0][Q-1:Q-3]}};

endmodule

// File: rtl/swan_serial_core.sv
// SWAN block cipher, one Feistel half-round per clock.
// Ports: clk, rst (sync, active-high), start (load-and-go), decrypt (mode,
// sampled with start), inp (block), key (master key), busy, ready, out ({R,L}).
// Decryption first runs the key schedule forward to its final value
// (PRECOMP) and then walks it backwards while undoing the half-rounds.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no result; waiting for start
// ST_PRECOMP | decrypt only: advancing key to its end value
// ST_RUN     | one half-round per cycle
// ST_DONE    | out holds the result, ready high
module swan_serial_core
    import swan_pkg::*;
#(
    parameter int          BLOCK_SIZE = 64,
    parameter int          KEY_SIZE   = 128,
    parameter int          ROUNDS     = 64,
    parameter int          PD         = 24,
    parameter logic [31:0] DELTA      = SWAN_DELTA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [BLOCK_SIZE-1:0] inp,
    input  logic [KEY_SIZE-1:0]   key,
    output logic                  busy,
    output logic                  ready,
    output logic [BLOCK_SIZE-1:0] out
);
    localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
    localparam int HALF_ROUNDS = 2 * ROUNDS;
    localparam int CW          = ($clog2(HALF_ROUNDS) < 7) ? 7 : $clog2(HALF_ROUNDS);

    if (!legal_sizes(BLOCK_SIZE, KEY_SIZE, ROUNDS, PD)) begin : g_bad_params
        $error("swan_serial_core: illegal BLOCK_SIZE/KEY_SIZE/ROUNDS/PD combination");
    end

    swan_state_t          state;
    logic [SIDE_SIZE-1:0] r_q;
    logic [SIDE_SIZE-1:0] l_q;
    logic [KEY_SIZE-1:0]  k_q;
    logic [SIDE_SIZE-1:0] rd_q;
    logic [CW-1:0]        hc_q;
    logic [CW-1:0]        pc_q;
    logic                 dec_q;
    logic                 busy_q;
    logic                 ready_q;

    logic [SIDE_SIZE-1:0] rd_fwd;
    logic [SIDE_SIZE-1:0] rd_inv;
    logic [KEY_SIZE-1:0]  k_fwd;
    logic [KEY_SIZE-1:0]  k_inv;
    logic [SIDE_SIZE-1:0] sk;
    logic                 sel_l;
    logic [SIDE_SIZE-1:0] f_in;
    logic [SIDE_SIZE-1:0] f_out;

    assign rd_fwd = rd_q + SIDE_SIZE'(DELTA);
    assign rd_inv = rd_q - SIDE_SIZE'(DELTA);
    assign k_fwd  = KEY_SIZE'(key_fwd(KMAX'(k_q), SMAX'(rd_fwd), KEY_SIZE, SIDE_SIZE, PD));
    assign k_inv  = KEY_SIZE'(key_inv(KMAX'(k_q), SMAX'(rd_q), KEY_SIZE, SIDE_SIZE, PD));

    // Decrypt draws its round key from the key one inverse step back, which is
    // the key encrypt used for the half-round being undone.
    assign sk = dec_q ? k_inv[KEY_SIZE-1 -: SIDE_SIZE] : k_q[KEY_SIZE-1 -: SIDE_SIZE];

    // sel_l: R ^= F(L); otherwise L ^= F(R).
    assign sel_l = hc_q[0] ^ dec_q;
    assign f_in  = sel_l ? l_q : r_q;

    swan_round_f #(
        .SIDE_SIZE(SIDE_SIZE)
    ) u_round_f (
        .x (f_in),
        .sk(sk),
        .y (f_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            r_q     <= '0;
            l_q     <= '0;
            k_q     <= '0;
            rd_q    <= '0;
            hc_q    <= '0;
            pc_q    <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (start) begin
            r_q     <= inp[BLOCK_SIZE-1 -: SIDE_SIZE];
            l_q     <= inp[SIDE_SIZE-1:0];
            k_q     <= key;
            rd_q    <= '0;
            hc_q    <= CW'(HALF_ROUNDS - 1);
            pc_q    <= CW'(HALF_ROUNDS - 1);
            dec_q   <= decrypt;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= decrypt ? ST_PRECOMP : ST_RUN;
        end else begin
            case (state)
                ST_PRECOMP: begin
                    k_q  <= k_fwd;
                    rd_q <= rd_fwd;
                    if (pc_q == '0) state <= ST_RUN;
                    else            pc_q  <= pc_q - 1'b1;
                end
                ST_RUN: begin
                    if (sel_l) r_q <= r_q ^ f_out;
                    else       l_q <= l_q ^ f_out;
                    if (dec_q) begin
                        k_q  <= k_inv;
                        rd_q <= rd_inv;
                    end else begin
                        k_q  <= k_fwd;
                        rd_q <= rd_fwd;
                    end
                    if (hc_q == '0) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        hc_q <= hc_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign out   = {r_q, l_q};

endmodule

// File: tb/tb_swan_serial_core.sv
module tb_swan_serial_core;

    localparam int H    = 128;
    localparam int PD_T = 24;
    localparam logic [255:0] DELTA_W = 256'h9e3779b9;
    localparam int SBOX_T [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    typedef struct {
        logic [255:0] out;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] msk(input int w);
        return (256'd1 << w) - 256'd1;
    endfunction

    function automatic logic [255:0] rl(input logic [255:0] v, input int r, input int w);
        return ((v << r) | (v >> (w - r))) & msk(w);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference F: quarters, S-box per bit column, diffusion, quarter rotation.
    function automatic logic [255:0] model_f(input logic [255:0] x, input logic [255:0] sk, input int s);
        int q = s / 4;
        int nib;
        int v;
        logic [255:0] t;
        logic [255:0] a [4];
        logic [255:0] b [4];
        logic [255:0] c [4];
        t = (x ^ sk) & msk(s);
        for (int j = 0; j < 4; j++) begin
            a[j] = (t >> (s - q * (j + 1))) & msk(q);
            b[j] = '0;
        end
        for (int i = 0; i < q; i++) begin
            nib = 0;
            for (int j = 0; j < 4; j++) nib = nib * 2 + int'(a[j][i]);
            v = SBOX_T[nib];
            for (int j = 0; j < 4; j++) if (((v >> (3 - j)) & 1) != 0) b[j][i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) c[j] = b[j] ^ rl(b[j], 1, q) ^ rl(b[j], 7, q);
        return (c[1] << (3 * q)) | (c[2] << (2 * q)) | (c[3] << q) | rl(c[0], 3, q);
    endfunction

    // Reference encryption: walk the key schedule forward, alternating halves.
    function automatic logic [255:0] model_enc(input logic [255:0] p, input logic [255:0] key,
                                               input int bs, input int ks);
        int s = bs / 2;
        logic [255:0] k, rd, r, l, sk, low;
        k  = key & msk(ks);
        rd = '0;
        r  = (p >> s) & msk(s);
        l  = p & msk(s);
        for (int i = 0; i < H; i++) begin
            sk = (k >> (ks - s)) & msk(s);
            if (i % 2 == 0) r = r ^ model_f(l, sk, s);
            else            l = l ^ model_f(r, sk, s);
            rd  = (rd + DELTA_W) & msk(s);
            k   = rl(k, ks - PD_T, ks);
            low = ((k & msk(s)) + rd) & msk(s);
            k   = (k & ~msk(s)) | low;
        end
        return (r << s) | l;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int BS = (g == 0) ? 64 : (g == 1) ? 128 : 256;
        localparam int KS = (g == 0) ? 128 : 256;

        logic          rst;
        logic          start;
        logic          decrypt;
        logic          busy;
        logic          ready;
        logic [BS-1:0] inp;
        logic [BS-1:0] out;
        logic [KS-1:0] key;

        exp_t sb[$];
        int   start_cyc  = -1;
        int   last_start = -1;
        int   busy_cnt   = 0;
        bit   ready_prev = 1'b0;
        bit   blk_done   = 1'b0;

        swan_serial_core #(
            .BLOCK_SIZE(BS),
            .KEY_SIZE  (KS)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .decrypt(decrypt),
            .inp    (inp),
            .key    (key),
            .busy   (busy),
            .ready  (ready),
            .out    (out)
        );

        always @(posedge clk) if (start === 1'b1 && rst === 1'b0) start_cyc <= cyc + 1;

        // Monitor: every rising ready consumes one scoreboard entry.
        always @(negedge clk) begin
            exp_t e;
            if (start_cyc != last_start) begin
                last_start = start_cyc;
                busy_cnt   = 0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (ready === 1'b1 && !ready_prev) begin
                if (sb.size() == 0) begin
                    check($sformatf("cfg%0d_ready_without_request", g), 256'(ready), 256'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("cfg%0d_out", g), 256'(out), e.out);
                    check($sformatf("cfg%0d_latency", g), 256'(cyc - start_cyc), 256'(e.lat));
                    check($sformatf("cfg%0d_busy_cycles", g), 256'(busy_cnt), 256'(e.lat));
                end
            end
            ready_prev = (ready === 1'b1);
        end

        task automatic issue(input logic [BS-1:0] d_in, input logic [KS-1:0] k, input logic dec);
            @(negedge clk);
            inp     = d_in;
            key     = k;
            decrypt = dec;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
        endtask

        task automatic wait_ready(input int budget);
            int n = 0;
            while (ready !== 1'b1 && n < budget) begin
                @(negedge clk);
                n++;
            end
            if (ready !== 1'b1) check($sformatf("cfg%0d_ready_timeout", g), 256'(ready), 256'd1);
        endtask

        task automatic round_trip(input logic [BS-1:0] p, input logic [KS-1:0] k);
            logic [BS-1:0] ct;
            ct = BS'(model_enc(256'(p), 256'(k), BS, KS));
            sb.push_back(exp_t'{256'(ct), H});
            issue(p, k, 1'b0);
            wait_ready(2 * H + 10);
            sb.push_back(exp_t'{256'(p), 2 * H});
            issue(ct, k, 1'b1);
            wait_ready(3 * H + 10);
        endtask

        task automatic do_reset();
            rst = 1'b1; start = 1'b0; decrypt = 1'b0; inp = '0; key = '0;
            repeat (3) @(negedge clk);
            check($sformatf("cfg%0d_reset_out", g), 256'(out), 256'd0);
            check($sformatf("cfg%0d_reset_ready", g), 256'(ready), 256'd0);
            check($sformatf("cfg%0d_reset_busy", g), 256'(busy), 256'd0);
            rst = 1'b0;
        endtask

        if (g == 0) begin : g_dir
            initial begin
                logic [BS-1:0] p, p2, ct;
                logic [KS-1:0] k, k2;
                do_reset();

                p  = BS'(64'h0123456789abcdef);
                k  = KS'(rnd256());
                ct = BS'(model_enc(256'(p), 256'(k), BS, KS));
                sb.push_back(exp_t'{256'(ct), H});
                issue(p, k, 1'b0);
                wait_ready(2 * H + 10);
                sb.push_back(exp_t'{256'(p), 2 * H});
                issue(ct, k, 1'b1);
                wait_ready(3 * H + 10);

                // DONE must ignore input changes.
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("hold_out", 256'(out), 256'(p));
                    check("hold_ready", 256'(ready), 256'd1);
                    inp = BS'(rnd256());
                    key = KS'(rnd256());
                end
                @(negedge clk);
                check("hold_out_end", 256'(out), 256'(p));

                // Restart mid-encrypt: only the second block may produce a result.
                p  = BS'(rnd256());  k  = KS'(rnd256());
                p2 = BS'(rnd256());  k2 = KS'(rnd256());
                issue(p, k, 1'b0);
                repeat (48) @(negedge clk);
                sb.push_back(exp_t'{model_enc(256'(p2), 256'(k2), BS, KS), H});
                issue(p2, k2, 1'b0);
                wait_ready(2 * H + 10);

                // Reset mid-decrypt, with a start that must be ignored.
                issue(BS'(rnd256()), KS'(rnd256()), 1'b1);
                repeat (69) @(negedge clk);
                rst = 1'b1; start = 1'b1; inp = BS'(rnd256());
                @(negedge clk);
                rst = 1'b0; start = 1'b0;
                check("rst_ready", 256'(ready), 256'd0);
                check("rst_busy", 256'(busy), 256'd0);
                check("rst_out", 256'(out), 256'd0);
                repeat (300) @(negedge clk);
                check("idle_ready", 256'(ready), 256'd0);
                check("idle_busy", 256'(busy), 256'd0);
                check("idle_out", 256'(out), 256'd0);

                for (int n = 0; n < 4; n++) round_trip(BS'(rnd256()), KS'(rnd256()));

                repeat (2) @(negedge clk);
                check("cfg0_scoreboard_empty", 256'(sb.size()), 256'd0);
                blk_done = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                for (int n = 0; n < 100; n++) round_trip(BS'(rnd256()), KS'(rnd256()));
                repeat (2) @(negedge clk);
                check($sformatf("cfg%0d_scoreboard_empty", g), 256'(sb.size()), 256'd0);
                blk_done = 1'b1;
            end
        end
    end

    initial begin
        wait (g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
